lane_serializer: RTL and testbench
==================================

Name: lane_serializer

Overview:
- Parametrised, sequential successor to the combinational word splitter.
- Accepts one DATA_W-bit word over a valid/ready handshake and emits its LANE_W-bit lanes one per accepted output beat, MSB-first or LSB-first.
- Can emit only part of a word (a selectable lane count).
- Sits between a word-wide producer (register file or bus) and a narrow consumer (byte-wide port or display driver).

Parameters:
- DATA_W, 32, input word width; must be an integer multiple of LANE_W.
- LANE_W, 8, output lane width.
- LANES, DATA_W/LANE_W (derived localparam, not overridable), lanes per word; must be ≥2.
- IDX_W, clog2(LANES) (derived), lane index width.
- CNT_W, clog2(LANES+1) (derived), lane-count field width.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, producer offers a word.
- in_ready, output, 1, block can accept a word this cycle (combinational).
- in_data, input, DATA_W, word to split.
- in_msb_first, input, 1, 1 = emit the highest lane first; 0 = emit lane 0 first.
- in_len, input, CNT_W, number of lanes to emit; 0 means LANES; values >LANES are clamped to LANES.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, consumer accepts the current lane.
- out_data, output, LANE_W, current lane value.
- out_idx, output, IDX_W, lane index of out_data within the original word.
- out_last, output, 1, current lane is the final lane of this word.
- word_cnt, output, 16, count of completed words; wraps from 16'hFFFF to 0.

Behaviour:
- Reset values (synchronous):
  - state = IDLE.
  - out_valid, out_data, out_idx, out_last, word_cnt, and the holding register all 0.
  - in_ready = 0 while reset is high.
- States: IDLE, SEND.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_data, direction and effective length L (L = LANES if in_len is 0 or >LANES), then go to SEND.
- SEND, first beat: appears the cycle after acceptance. Latency is 1 cycle from the accept edge to out_valid = 1.
- Lane selection:
  - MSB-first: out_idx runs LANES-1 down to LANES-L.
  - LSB-first: out_idx runs 0 up to L-1.
  - out_data = word[out_idx*LANE_W +: LANE_W].
- Beat transfer occurs on out_valid && out_ready. The next lane appears the following cycle; there are no bubbles between lanes.
- Stall: while out_valid && !out_ready, out_data, out_idx and out_last hold stable. out_valid never drops without a transfer.
- out_last = 1 exactly on the L-th lane of the word. For L = 1, the first beat is also the last.
- Completion: on the transfer of the out_last beat:
  - word_cnt increments.
  - If no new word is accepted in that cycle: out_valid = 0 and state returns to IDLE.
- Back-to-back: in SEND, in_ready = out_valid && out_ready && out_last (combinational). A word accepted in that same cycle starts SEND immediately, so its first lane is valid next cycle and the output has zero idle cycles between words.
- in_ready is 0 at all other times in SEND. in_data, in_len and in_msb_first are ignored when no handshake occurs.
- out_valid and out_data must not depend combinationally on in_valid; they come from registers only.
- Reset mid-word: the partially sent word is discarded, word_cnt returns to 0 and out_valid drops the next edge. The word is not replayed.
- Reset has priority over every simultaneous handshake.

Test Plan:
- MSB-first, full word: in_data = 32'h86DEF0A3, in_len = 0, out_ready held 1 → out_data 86, DE, F0, A3 on 4 consecutive cycles; out_idx 3, 2, 1, 0; out_last only on A3; word_cnt 0→1; first beat 1 cycle after accept.
- LSB-first with backpressure: same word, in_msb_first = 0, out_ready low for 3 cycles on the 2nd beat → sequence A3, F0, DE, 86. F0 / idx 1 holds stable through the stall. out_valid never drops.
- Partial and clamped length:
  - in_len = 2, MSB-first → 86, DE, with out_last on DE.
  - in_len = 1, LSB-first → single beat A3 with out_last = 1.
  - in_len = 7 → clamped to 4 beats.
- Back-to-back words: second word 32'h12345678 offered with in_valid continuously high → accepted on the cycle the A3 last beat transfers. Next cycle outputs 12. No idle cycle. word_cnt = 2 after the final 78.
- Reset mid-word: reset asserted after 2 of 4 beats → next cycle out_valid = 0, word_cnt = 0, in_ready = 1 after reset deasserts. A new word 32'hCAFEBABE is then emitted from CA cleanly.
- Parametric instance DATA_W = 16, LANE_W = 4: in_data 16'hBEEF, MSB-first → B, E, E, F with out_idx 3..0. word_cnt wrap is forced from 16'hFFFF → 0 on the next completion.

Source files
------------

// File: rtl/lane_serializer_if.sv
// Word-in / lane-out stream bundle for lane_serializer; master drives words and out_ready, slave is the serializer.
interface lane_serializer_if #(
   parameter int DATA_W = 32,
   parameter int LANE_W = 8
);
   localparam int LANES = DATA_W / LANE_W;
   localparam int IDX_W = $clog2(LANES);
   localparam int CNT_W = $clog2(LANES + 1);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_msb_first;
   logic [CNT_W-1:0]  in_len;

   logic              out_valid;
   logic              out_ready;
   logic [LANE_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;

   modport master (
      output in_valid, in_data, in_msb_first, in_len, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_data, in_msb_first, in_len, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/lane_serializer.sv
// Splits one DATA_W word into LANE_W lanes (MSB- or LSB-first, optional partial count); first lane 1 cycle after accept.
// Lanes hold stable while out_ready is low; a new word may load on the last-lane transfer for gap-free output.
module lane_serializer #(
   parameter int DATA_W = 32,
   parameter int LANE_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   lane_serializer_if.slave bus,
   output logic [15:0]      word_cnt
);
   localparam int LANES = DATA_W / LANE_W;
   localparam int IDX_W = $clog2(LANES);
   localparam int CNT_W = $clog2(LANES + 1);

   typedef enum logic [0:0] {IDLE, SEND} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] word;
      logic              msb_first;
      logic [IDX_W-1:0]  last_idx;
   } hold_t;

   state_t            state_q, state_d;
   hold_t             hold_q, hold_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              out_valid_q, out_valid_d;
   logic [LANE_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic [15:0]       word_cnt_q, word_cnt_d;

   logic              in_ready;
   logic              xfer;
   logic              accept;
   logic [CNT_W-1:0]  len_eff;
   logic [IDX_W-1:0]  first_idx;
   logic [IDX_W-1:0]  last_idx;
   logic [IDX_W-1:0]  step_idx;

   function automatic logic [LANE_W-1:0] lane_of(input logic [DATA_W-1:0] w,
                                                 input logic [IDX_W-1:0]  i);
      return w[int'(i)*LANE_W +: LANE_W];
   endfunction

   // Incoming word decode: clamp the lane count and find the first/last lane index.
   always_comb begin
      len_eff = bus.in_len;
      if (bus.in_len == '0 || bus.in_len > CNT_W'(LANES)) begin
         len_eff = CNT_W'(LANES);
      end
      first_idx = bus.in_msb_first ? IDX_W'(LANES - 1) : '0;
      last_idx  = bus.in_msb_first ? IDX_W'(LANES - int'(len_eff))
                                   : IDX_W'(int'(len_eff) - 1);
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      word_cnt_d  = word_cnt_q;
      in_ready    = 1'b0;
      xfer        = out_valid_q && bus.out_ready;
      step_idx    = hold_q.msb_first ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);

      // In SEND the only opening for a new word is the cycle its predecessor's last lane leaves.
      case (state_q)
         IDLE:    in_ready = !reset;
         SEND:    in_ready = !reset && xfer && out_last_q;
         default: in_ready = 1'b0;
      endcase
      accept = bus.in_valid && in_ready;

      if (xfer) begin
         if (out_last_q) begin
            out_valid_d = 1'b0;
            word_cnt_d  = word_cnt_q + 16'd1;
            state_d     = IDLE;
         end else begin
            idx_d      = step_idx;
            out_data_d = lane_of(hold_q.word, step_idx);
            out_last_d = (step_idx == hold_q.last_idx);
         end
      end

      if (accept) begin
         hold_d      = '{word: bus.in_data, msb_first: bus.in_msb_first, last_idx: last_idx};
         idx_d       = first_idx;
         out_valid_d = 1'b1;
         out_data_d  = lane_of(bus.in_data, first_idx);
         out_last_d  = (len_eff == CNT_W'(1));
         state_d     = SEND;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = out_last_q;
   assign word_cnt      = word_cnt_q;
endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: queue-based lane model checked every cycle on a 32/8 and a 16/4 instance,
// plus literal expectations for the directed scenarios and the word counter wrap.
`timescale 1ns/1ps
module tb_lane_serializer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rst16;
   logic [15:0] word_cnt;
   logic [15:0] word_cnt16;

   lane_serializer_if #(.DATA_W(32), .LANE_W(8)) bus();
   lane_serializer_if #(.DATA_W(16), .LANE_W(4)) bus16();

   lane_serializer #(.DATA_W(32), .LANE_W(8)) dut (
      .clk(clk), .reset(rst), .bus(bus), .word_cnt(word_cnt)
   );
   lane_serializer #(.DATA_W(16), .LANE_W(4)) dut16 (
      .clk(clk), .reset(rst16), .bus(bus16), .word_cnt(word_cnt16)
   );

   typedef struct packed {
      logic [7:0] dat;
      logic [1:0] idx;
      logic       last;
   } beat_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        mon_on = 1'b0;
   logic        done16 = 1'b0;
   beat_t       mq[2][$];
   logic [15:0] cnt_m[2];
   beat_t       log_b[2][$];
   int          log_c[2][$];
   int          acc_c[2][$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected lanes are computed from the word, direction and clamped length at handshake time.
   task automatic step(input int i, input int lw, input logic r,
                       input logic ivld, input logic irdy, input logic [31:0] idat,
                       input logic imsb, input logic [2:0] ilen,
                       input logic ovld, input logic ordy, input logic [7:0] odat,
                       input logic [1:0] oidx, input logic olast, input logic [15:0] wc);
      logic  rdy_m;
      string t;
      int    len;
      t     = $sformatf("u%0d_", i);
      rdy_m = !r && (mq[i].size() == 0 || (mq[i].size() == 1 && ordy));
      chk({t, "in_ready"}, irdy, rdy_m);
      chk({t, "out_valid"}, ovld, mq[i].size() != 0);
      chk({t, "word_cnt"}, wc, cnt_m[i]);
      if (ovld && mq[i].size() != 0) begin
         chk({t, "out_data"}, odat, mq[i][0].dat);
         chk({t, "out_idx"}, oidx, mq[i][0].idx);
         chk({t, "out_last"}, olast, mq[i][0].last);
      end
      if (r) begin
         mq[i].delete();
         cnt_m[i] = 16'h0;
      end else begin
         if (mq[i].size() != 0 && ordy) begin
            log_b[i].push_back(mq[i][0]);
            log_c[i].push_back(cyc);
            if (mq[i][0].last) cnt_m[i] = cnt_m[i] + 16'h1;
            void'(mq[i].pop_front());
         end
         if (ivld && rdy_m) begin
            len = (ilen == 3'd0 || ilen > 3'd4) ? 4 : int'(ilen);
            acc_c[i].push_back(cyc);
            for (int k = 0; k < len; k++) begin
               beat_t b;
               int    ix;
               ix     = imsb ? 3 - k : k;
               b.idx  = 2'(ix);
               b.dat  = 8'((idat >> (ix * lw)) & ((32'd1 << lw) - 32'd1));
               b.last = (k == len - 1);
               mq[i].push_back(b);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (mon_on) begin
         step(0, 8, rst, bus.in_valid, bus.in_ready, bus.in_data, bus.in_msb_first, bus.in_len,
              bus.out_valid, bus.out_ready, bus.out_data, bus.out_idx, bus.out_last, word_cnt);
         step(1, 4, rst16, bus16.in_valid, bus16.in_ready, {16'h0, bus16.in_data},
              bus16.in_msb_first, bus16.in_len, bus16.out_valid, bus16.out_ready,
              {4'h0, bus16.out_data}, bus16.out_idx, bus16.out_last, word_cnt16);
      end
   end

   task automatic chk_beat(input int i, input string tag, input int k,
                           input logic [7:0] d, input logic [1:0] ix, input logic l);
      if (k >= log_b[i].size()) begin
         checks++;
         errors++;
         $display("FAIL %s beat %0d: got none, expected %0h", tag, k, d);
      end else begin
         chk($sformatf("%s_dat%0d", tag, k), log_b[i][k].dat, d);
         chk($sformatf("%s_idx%0d", tag, k), log_b[i][k].idx, ix);
         chk($sformatf("%s_last%0d", tag, k), log_b[i][k].last, l);
      end
   endtask

   task automatic clear_logs(input int i);
      log_b[i].delete();
      log_c[i].delete();
      acc_c[i].delete();
   endtask

   task automatic offer(input logic [31:0] d, input logic m, input logic [2:0] l);
      int n;
      bus.in_valid     = 1'b1;
      bus.in_data      = d;
      bus.in_msb_first = m;
      bus.in_len       = l;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      if (n == 50) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready got 0, expected 1");
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      for (n = 0; n < 60; n++) begin
         @(negedge clk);
         if (!bus.out_valid) break;
      end
      if (n == 60) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: out_valid got 1, expected 0");
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      int n;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_msb_first = 1'b0;
      bus.in_len = '0;
      bus.out_ready = 1'b1;
      cnt_m[0] = 16'h0;
      cnt_m[1] = 16'h0;
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_word_cnt", word_cnt, 16'h0);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;

      // MSB-first full word
      clear_logs(0);
      offer(32'h86DEF0A3, 1'b1, 3'd0);
      drain();
      chk_beat(0, "msb", 0, 8'h86, 2'd3, 1'b0);
      chk_beat(0, "msb", 1, 8'hDE, 2'd2, 1'b0);
      chk_beat(0, "msb", 2, 8'hF0, 2'd1, 1'b0);
      chk_beat(0, "msb", 3, 8'hA3, 2'd0, 1'b1);
      for (int k = 0; k < 4; k++) chk($sformatf("msb_cycle%0d", k), log_c[0][k], acc_c[0][0] + 1 + k);
      chk("msb_word_cnt", word_cnt, 16'd1);

      // LSB-first, 3-cycle stall on the second lane
      clear_logs(0);
      offer(32'h86DEF0A3, 1'b0, 3'd0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("stall_dat", bus.out_data, 8'hF0);
      chk("stall_idx", bus.out_idx, 2'd1);
      repeat (3) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();
      chk_beat(0, "lsb", 0, 8'hA3, 2'd0, 1'b0);
      chk_beat(0, "lsb", 1, 8'hF0, 2'd1, 1'b0);
      chk_beat(0, "lsb", 2, 8'hDE, 2'd2, 1'b0);
      chk_beat(0, "lsb", 3, 8'h86, 2'd3, 1'b1);
      chk("lsb_stall_gap", log_c[0][1] - log_c[0][0], 4);
      chk("lsb_word_cnt", word_cnt, 16'd2);

      // Partial and clamped lengths
      clear_logs(0);
      offer(32'h86DEF0A3, 1'b1, 3'd2);
      drain();
      chk("len2_beats", log_b[0].size(), 2);
      chk_beat(0, "len2", 0, 8'h86, 2'd3, 1'b0);
      chk_beat(0, "len2", 1, 8'hDE, 2'd2, 1'b1);
      clear_logs(0);
      offer(32'h86DEF0A3, 1'b0, 3'd1);
      drain();
      chk("len1_beats", log_b[0].size(), 1);
      chk_beat(0, "len1", 0, 8'hA3, 2'd0, 1'b1);
      clear_logs(0);
      offer(32'h86DEF0A3, 1'b1, 3'd7);
      drain();
      chk("len7_beats", log_b[0].size(), 4);
      chk_beat(0, "len7", 3, 8'hA3, 2'd0, 1'b1);
      chk("len_word_cnt", word_cnt, 16'd5);

      // Back-to-back words after a fresh reset
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs(0);
      offer(32'h86DEF0A3, 1'b1, 3'd0);
      offer(32'h12345678, 1'b1, 3'd0);
      drain();
      chk_beat(0, "b2b", 3, 8'hA3, 2'd0, 1'b1);
      chk_beat(0, "b2b", 4, 8'h12, 2'd3, 1'b0);
      chk_beat(0, "b2b", 7, 8'h78, 2'd0, 1'b1);
      chk("b2b_accept_on_last", acc_c[0][1], log_c[0][3]);
      chk("b2b_no_gap", log_c[0][4], log_c[0][3] + 1);
      chk("b2b_word_cnt", word_cnt, 16'd2);

      // Reset after two lanes of a word
      offer(32'h86DEF0A3, 1'b1, 3'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", bus.out_valid, 1'b0);
      chk("midrst_word_cnt", word_cnt, 16'h0);
      chk("midrst_in_ready_after", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      clear_logs(0);
      offer(32'hCAFEBABE, 1'b1, 3'd0);
      drain();
      chk("cafe_beats", log_b[0].size(), 4);
      chk_beat(0, "cafe", 0, 8'hCA, 2'd3, 1'b0);
      chk_beat(0, "cafe", 1, 8'hFE, 2'd2, 1'b0);
      chk_beat(0, "cafe", 2, 8'hBA, 2'd1, 1'b0);
      chk_beat(0, "cafe", 3, 8'hBE, 2'd0, 1'b1);
      chk("cafe_word_cnt", word_cnt, 16'd1);

      // Random traffic, backpressure and occasional reset
      for (int c = 0; c < 3000; c++) begin
         bus.in_valid     = 1'($urandom_range(0, 1));
         bus.in_data      = $urandom;
         bus.in_msb_first = 1'($urandom_range(0, 1));
         bus.in_len       = 3'($urandom_range(0, 7));
         bus.out_ready    = ($urandom_range(0, 3) != 0);
         rst              = ($urandom_range(0, 299) == 0);
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b0;
      drain();
      clear_logs(0);

      for (n = 0; n < 80000 && !done16; n++) @(posedge clk);
      if (!done16) begin
         checks++;
         errors++;
         $display("FAIL done16_timeout: got 0, expected 1");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : seq16
      int n;
      rst16 = 1'b1;
      bus16.in_valid = 1'b0;
      bus16.in_data = '0;
      bus16.in_msb_first = 1'b0;
      bus16.in_len = '0;
      bus16.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst16 = 1'b0;
      bus16.in_valid     = 1'b1;
      bus16.in_data      = 16'hBEEF;
      bus16.in_msb_first = 1'b1;
      bus16.in_len       = 3'd0;
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk_beat(1, "beef", 0, 8'hB, 2'd3, 1'b0);
      chk_beat(1, "beef", 1, 8'hE, 2'd2, 1'b0);
      chk_beat(1, "beef", 2, 8'hE, 2'd1, 1'b0);
      chk_beat(1, "beef", 3, 8'hF, 2'd0, 1'b1);
      chk("beef_word_cnt", word_cnt16, 16'd1);
      clear_logs(1);

      // Single-lane words back to back until the counter reaches its top value
      bus16.in_valid     = 1'b1;
      bus16.in_data      = 16'h1234;
      bus16.in_msb_first = 1'b0;
      bus16.in_len       = 3'd1;
      for (n = 0; n < 70000; n++) begin
         @(negedge clk);
         if (word_cnt16 == 16'hFFFF) break;
         if ((n % 4096) == 0) clear_logs(1);
      end
      chk("cnt16_reach_ffff", word_cnt16, 16'hFFFF);
      chk("cnt16_last_pending", bus16.out_last, 1'b1);
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
      @(negedge clk);
      chk("cnt16_wrap", word_cnt16, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("cnt16_after_wrap", word_cnt16, 16'h1);
      chk("cnt16_idle_valid", bus16.out_valid, 1'b0);
      clear_logs(1);
      done16 = 1'b1;
   end
endmodule
